// File: rtl/dll_pkg.sv
// Shared data-link-layer types: sequence width, Ack/Nak FSM states and
// modular sequence distance used by the transmit-side Ack/Nak logic.
package dll_pkg;

  localparam int SEQ_BITS = 12;

  typedef logic [SEQ_BITS-1:0] seq_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REPLAY
  } ack_nak_state_t;

  function automatic seq_t seq_diff(input seq_t a, input seq_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/dll_replay_timer.sv
// Replay timer: counts while run is high, saturates at LIMIT, flags expiry.
module dll_replay_timer #(
  parameter int LIMIT = 711
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run && count != CNT_W'(LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire_o = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/dll_ack_nak_handler.sv
// Transmit-side Ack/Nak processor: tracks sequence window, turns Ack/Nak
// DLLPs into retry-buffer purges, and drives replay/retrain requests.
module dll_ack_nak_handler
  import dll_pkg::*;
#(
  parameter int REPLAY_TIMER_LIMIT = 711,
  parameter int REPLAY_NUM_BITS    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tlp_sent_i,
  output logic [SEQ_BITS-1:0] next_seq_o,
  output logic                tx_stall_o,
  input  logic                dllp_valid_i,
  input  logic                dllp_nak_i,
  input  logic [SEQ_BITS-1:0] dllp_seq_i,
  output logic                purge_valid_o,
  output logic [SEQ_BITS-1:0] purge_seq_o,
  output logic                replay_req_o,
  input  logic                replay_ack_i,
  input  logic                replay_done_i,
  output logic                retrain_req_o,
  output logic                dllp_err_o
);

  // Half the sequence space minus one keeps Ack/Nak numbers unambiguous.
  localparam seq_t STALL_THRESH = seq_t'((1 << (SEQ_BITS - 1)) - 1);

  seq_t                       next_seq;
  seq_t                       ackd_seq;
  seq_t                       outstanding;
  seq_t                       dllp_dist;
  logic [REPLAY_NUM_BITS-1:0] replay_num;
  logic [REPLAY_NUM_BITS-1:0] replay_num_base;
  ack_nak_state_t             state;
  logic                       in_window;
  logic                       fwd_progress;
  logic                       nak_valid;
  logic                       expire;
  logic                       go_req;
  logic                       timer_run;
  logic                       timer_clear;

  assign outstanding  = seq_diff(seq_diff(next_seq, ackd_seq), seq_t'(1));
  assign dllp_dist    = seq_diff(dllp_seq_i, ackd_seq);
  assign in_window    = (dllp_dist <= outstanding);
  assign fwd_progress = dllp_valid_i && in_window && (dllp_dist != '0);
  assign nak_valid    = dllp_valid_i && in_window && dllp_nak_i;

  // A forward-progress Ack beats a simultaneous timer expiry; a Nak always replays.
  assign go_req = (state == IDLE) && (nak_valid || (expire && !fwd_progress));

  assign timer_run   = (state == IDLE) && (outstanding != '0);
  assign timer_clear = !timer_run || go_req || fwd_progress;

  // Purge happens first, so a Nak that also acknowledges counts from zero.
  assign replay_num_base = fwd_progress ? '0 : replay_num;

  assign next_seq_o  = next_seq;
  assign purge_seq_o = ackd_seq;
  assign tx_stall_o  = (outstanding >= STALL_THRESH);

  dll_replay_timer #(
    .LIMIT(REPLAY_TIMER_LIMIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (timer_run),
    .clear   (timer_clear),
    .expire_o(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      next_seq      <= '0;
      ackd_seq      <= '1;
      replay_num    <= '0;
      replay_req_o  <= 1'b0;
      purge_valid_o <= 1'b0;
      retrain_req_o <= 1'b0;
      dllp_err_o    <= 1'b0;
    end else begin
      purge_valid_o <= fwd_progress;
      dllp_err_o    <= dllp_valid_i && !in_window;
      retrain_req_o <= 1'b0;
      replay_num    <= replay_num_base;
      if (tlp_sent_i) begin
        next_seq <= next_seq + 1'b1;
      end
      if (fwd_progress) begin
        ackd_seq <= dllp_seq_i;
      end
      case (state)
        IDLE: begin
          if (go_req) begin
            state         <= REQ;
            replay_req_o  <= 1'b1;
            replay_num    <= replay_num_base + 1'b1;
            retrain_req_o <= &replay_num_base;
          end
        end
        REQ: begin
          if (replay_ack_i) begin
            state        <= REPLAY;
            replay_req_o <= 1'b0;
          end
        end
        REPLAY: begin
          if (replay_done_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          replay_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dll_ack_nak_handler.sv
// Bench for dll_ack_nak_handler: directed scenarios plus randomized traffic
// compared against a queue-based model of the outstanding TLP list.
module tb_dll_ack_nak_handler;
  import dll_pkg::*;

  localparam int LIMIT = 711;
  localparam int MODN  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tlp_sent_i = 1'b0;
  logic        dllp_valid_i = 1'b0;
  logic        dllp_nak_i = 1'b0;
  logic [11:0] dllp_seq_i = 12'd0;
  logic        replay_ack_i = 1'b0;
  logic        replay_done_i = 1'b0;
  logic [11:0] next_seq_o;
  logic [11:0] purge_seq_o;
  logic        tx_stall_o;
  logic        purge_valid_o;
  logic        replay_req_o;
  logic        retrain_req_o;
  logic        dllp_err_o;

  int checks = 0;
  int failures = 0;

  // Reference model: explicit list of unacknowledged sequence numbers.
  int m_q[$];
  int m_next, m_ackd, m_phase, m_timer, m_rnum;
  bit e_purge, e_err, e_retrain;

  dll_ack_nak_handler dut (
    .clk          (clk),
    .rst          (rst),
    .tlp_sent_i   (tlp_sent_i),
    .next_seq_o   (next_seq_o),
    .tx_stall_o   (tx_stall_o),
    .dllp_valid_i (dllp_valid_i),
    .dllp_nak_i   (dllp_nak_i),
    .dllp_seq_i   (dllp_seq_i),
    .purge_valid_o(purge_valid_o),
    .purge_seq_o  (purge_seq_o),
    .replay_req_o (replay_req_o),
    .replay_ack_i (replay_ack_i),
    .replay_done_i(replay_done_i),
    .retrain_req_o(retrain_req_o),
    .dllp_err_o   (dllp_err_o)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_q.delete();
    m_next = 0; m_ackd = MODN - 1; m_phase = 0; m_timer = 0; m_rnum = 0;
    e_purge = 0; e_err = 0; e_retrain = 0;
  endtask

  task automatic m_step(input bit sent, input bit dv, input bit nak, input int seq,
                        input bit ack, input bit done);
    bit valid, fwd, expired, start, busy;
    int pos;
    busy = (m_q.size() != 0);
    e_purge = 0; e_err = 0; e_retrain = 0; valid = 0; fwd = 0; pos = -1;
    if (dv) begin
      for (int i = 0; i < m_q.size(); i++) if (m_q[i] == seq) pos = i;
      if (seq == m_ackd) valid = 1;
      else if (pos >= 0) begin valid = 1; fwd = 1; end
      else e_err = 1;
    end
    expired = (m_phase == 0) && (m_timer >= LIMIT);
    if (fwd) begin
      for (int i = 0; i <= pos; i++) void'(m_q.pop_front());
      m_ackd = seq; e_purge = 1; m_rnum = 0;
    end
    start = (m_phase == 0) && ((valid && nak) || (expired && !fwd));
    if (m_phase != 0 || start || fwd || !busy) m_timer = 0;
    else m_timer++;
    if (start) begin
      if (m_rnum == 3) begin m_rnum = 0; e_retrain = 1; end
      else m_rnum++;
      m_phase = 1;
    end else if (m_phase == 1 && ack) m_phase = 2;
    else if (m_phase == 2 && done) m_phase = 0;
    if (sent) begin
      m_q.push_back(m_next);
      m_next = (m_next + 1) % MODN;
    end
  endtask

  task automatic cycle(input bit sent, input bit dv, input bit nak, input int seq,
                       input bit ack, input bit done);
    if (sent) begin
      checks++;
      if (tx_stall_o !== 1'b0 || dut.state !== IDLE) begin
        failures++;
        $display("FAIL tlp_sent_legal stall=%0b state=%0d required stall=0 state=IDLE",
                 tx_stall_o, dut.state);
      end
    end
    tlp_sent_i = sent; dllp_valid_i = dv; dllp_nak_i = nak; dllp_seq_i = seq[11:0];
    replay_ack_i = ack; replay_done_i = done;
    m_step(sent, dv, nak, seq, ack, done);
    @(posedge clk); #1;
    tlp_sent_i = 0; dllp_valid_i = 0; dllp_nak_i = 0; replay_ack_i = 0; replay_done_i = 0;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (next_seq_o !== 12'd0) begin
      failures++; $display("FAIL reset_next_seq got=%0d exp=0", next_seq_o);
    end
    checks++;
    if (purge_seq_o !== 12'd4095) begin
      failures++; $display("FAIL reset_purge_seq got=%0d exp=4095", purge_seq_o);
    end
    checks++;
    if ({purge_valid_o, dllp_err_o, replay_req_o, retrain_req_o, tx_stall_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {purge_valid_o, dllp_err_o, replay_req_o, retrain_req_o, tx_stall_o});
    end
    checks++;
    if (dut.replay_num !== 2'd0 || dut.state !== IDLE) begin
      failures++; $display("FAIL reset_state rnum=%0d state=%0d exp 0/IDLE", dut.replay_num, dut.state);
    end
  endtask

  task automatic test_basic_ack();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 2, 0, 0);
    checks++;
    if (purge_valid_o !== 1'b1 || purge_seq_o !== 12'd2) begin
      failures++; $display("FAIL ack_purge valid=%0b seq=%0d exp 1/2", purge_valid_o, purge_seq_o);
    end
    checks++;
    if (dut.outstanding !== 12'd2) begin
      failures++; $display("FAIL ack_outstanding got=%0d exp=2", dut.outstanding);
    end
    checks++;
    if (next_seq_o !== 12'd5) begin
      failures++; $display("FAIL ack_next_seq got=%0d exp=5", next_seq_o);
    end
    idle();
    checks++;
    if (purge_valid_o !== 1'b0) begin
      failures++; $display("FAIL ack_purge_pulse got=%0b exp=0", purge_valid_o);
    end
  endtask

  task automatic test_nak();
    bit dropped;
    int hold;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    checks++;
    if (purge_valid_o !== 1'b1 || purge_seq_o !== 12'd0 || replay_req_o !== 1'b1
        || retrain_req_o !== 1'b0) begin
      failures++;
      $display("FAIL nak_purge_req pv=%0b ps=%0d req=%0b rt=%0b exp 1/0/1/0",
               purge_valid_o, purge_seq_o, replay_req_o, retrain_req_o);
    end
    dropped = 0;
    hold = $urandom_range(1, 6);
    for (int i = 0; i < hold; i++) begin
      idle();
      if (replay_req_o !== 1'b1) dropped = 1;
    end
    checks++;
    if (dropped) begin
      failures++; $display("FAIL nak_req_hold got=dropped exp=held for %0d cycles", hold);
    end
    cycle(0, 0, 0, 0, 1, 0);
    checks++;
    if (replay_req_o !== 1'b0) begin
      failures++; $display("FAIL nak_req_drop got=%0b exp=0", replay_req_o);
    end
    idle();
    cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (dut.state !== IDLE || dut.replay_num !== 2'd1) begin
      failures++; $display("FAIL nak_done state=%0d rnum=%0d exp IDLE/1", dut.state, dut.replay_num);
    end
  endtask

  task automatic test_timer_retrain();
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    for (int r = 1; r <= 4; r++) begin
      int n;
      bit seen;
      n = 0; seen = 0;
      while (n < 800 && !seen) begin
        idle();
        n++;
        if (replay_req_o === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || n != 712) begin
        failures++; $display("FAIL timer_delay round=%0d got=%0d seen=%0b exp=712", r, n, seen);
      end
      checks++;
      if (retrain_req_o !== (r == 4)) begin
        failures++; $display("FAIL retrain round=%0d got=%0b exp=%0b", r, retrain_req_o, r == 4);
      end
      checks++;
      if (dut.replay_num !== 2'(r % 4)) begin
        failures++; $display("FAIL timer_rnum round=%0d got=%0d exp=%0d", r, dut.replay_num, r % 4);
      end
      cycle(0, 0, 0, 0, 1, 0);
      idle();
      cycle(0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4094; i++) cycle(1, 1, 0, i - 1, 0, 0);
    cycle(0, 1, 0, 4093, 0, 0);
    checks++;
    if (next_seq_o !== 12'd4094 || purge_seq_o !== 12'd4093) begin
      failures++; $display("FAIL wrap_setup next=%0d ackd=%0d exp 4094/4093", next_seq_o, purge_seq_o);
    end
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (purge_valid_o !== 1'b1 || purge_seq_o !== 12'd0 || dut.outstanding !== 12'd1
        || next_seq_o !== 12'd2) begin
      failures++;
      $display("FAIL wrap_ack pv=%0b ps=%0d out=%0d next=%0d exp 1/0/1/2",
               purge_valid_o, purge_seq_o, dut.outstanding, next_seq_o);
    end
    cycle(0, 1, 0, 4000, 0, 0);
    checks++;
    if (dllp_err_o !== 1'b1 || purge_valid_o !== 1'b0) begin
      failures++; $display("FAIL wrap_err err=%0b pv=%0b exp 1/0", dllp_err_o, purge_valid_o);
    end
    checks++;
    if (purge_seq_o !== 12'd0 || dut.outstanding !== 12'd1 || next_seq_o !== 12'd2) begin
      failures++;
      $display("FAIL wrap_nochange ps=%0d out=%0d next=%0d exp 0/1/2",
               purge_seq_o, dut.outstanding, next_seq_o);
    end
    idle();
    checks++;
    if (dllp_err_o !== 1'b0) begin
      failures++; $display("FAIL wrap_err_pulse got=%0b exp=0", dllp_err_o);
    end
  endtask

  task automatic test_stall();
    int guard;
    bit seen_2046;
    do_reset();
    guard = 0; seen_2046 = 0;
    while (m_q.size() < 2047 && guard < 6000) begin
      if (m_phase == 1) cycle(0, 0, 0, 0, 1, 0);
      else if (m_phase == 2) cycle(0, 0, 0, 0, 0, 1);
      else begin
        if (m_q.size() == 2046 && !seen_2046) begin
          seen_2046 = 1;
          checks++;
          if (tx_stall_o !== 1'b0) begin
            failures++; $display("FAIL stall_2046 got=%0b exp=0", tx_stall_o);
          end
        end
        cycle(1, 0, 0, 0, 0, 0);
      end
      guard++;
    end
    if (guard >= 6000) begin
      failures++; $display("FAIL stall_fill_timeout sent=%0d required=2047", m_q.size());
    end
    checks++;
    if (tx_stall_o !== 1'b1 || next_seq_o !== 12'd2047) begin
      failures++; $display("FAIL stall_full stall=%0b next=%0d exp 1/2047", tx_stall_o, next_seq_o);
    end
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (tx_stall_o !== 1'b0 || purge_seq_o !== 12'd0) begin
      failures++; $display("FAIL stall_release stall=%0b ps=%0d exp 0/0", tx_stall_o, purge_seq_o);
    end
  endtask

  task automatic test_ack_wins();
    int n;
    bit seen;
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    n = 0;
    while (m_timer < LIMIT && n < 800) begin idle(); n++; end
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (replay_req_o !== 1'b0 || purge_valid_o !== 1'b1 || dut.replay_num !== 2'd0) begin
      failures++;
      $display("FAIL ack_wins req=%0b pv=%0b rnum=%0d exp 0/1/0", replay_req_o, purge_valid_o, dut.replay_num);
    end
    n = 0; seen = 0;
    while (n < 800 && !seen) begin
      idle();
      n++;
      if (replay_req_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != 712) begin
      failures++; $display("FAIL ack_wins_timer got=%0d seen=%0b exp=712", n, seen);
    end
  endtask

  task automatic test_expiry_nak_rst();
    int n;
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    n = 0;
    while (m_timer < LIMIT && n < 800) begin idle(); n++; end
    checks++;
    if (replay_req_o !== 1'b0) begin
      failures++; $display("FAIL expiry_pre_req got=%0b exp=0", replay_req_o);
    end
    cycle(0, 1, 1, 4095, 0, 0);
    checks++;
    if (replay_req_o !== 1'b1 || dut.replay_num !== 2'd1 || retrain_req_o !== 1'b0) begin
      failures++;
      $display("FAIL expiry_nak req=%0b rnum=%0d rt=%0b exp 1/1/0", replay_req_o, dut.replay_num, retrain_req_o);
    end
    cycle(0, 0, 0, 0, 1, 0);
    idle();
    checks++;
    if (dut.replay_num !== 2'd1 || dut.state !== REPLAY) begin
      failures++; $display("FAIL expiry_single rnum=%0d state=%0d exp 1/REPLAY", dut.replay_num, dut.state);
    end
    rst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (next_seq_o !== 12'd0 || purge_seq_o !== 12'd4095 || dut.state !== IDLE
        || {purge_valid_o, dllp_err_o, replay_req_o, retrain_req_o, tx_stall_o} !== 5'b0) begin
      failures++;
      $display("FAIL rst_replay next=%0d ps=%0d state=%0d flags=%b exp 0/4095/IDLE/00000",
               next_seq_o, purge_seq_o, dut.state,
               {purge_valid_o, dllp_err_o, replay_req_o, retrain_req_o, tx_stall_o});
    end
  endtask

  task automatic test_random();
    logic [28:0] got, exp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit s, dv, nk, a, d;
      int sq;
      s = 0; dv = 0; nk = 0; a = 0; d = 0; sq = 0;
      if (m_phase == 0 && m_q.size() < 2047 && $urandom_range(0, 99) < 60) s = 1;
      if ($urandom_range(0, 99) < 15) begin
        dv = 1;
        nk = ($urandom_range(0, 99) < 25);
        case ($urandom_range(0, 3))
          0: sq = m_ackd;
          1, 2: begin
            if (m_q.size() != 0) sq = m_q[$urandom_range(0, m_q.size() - 1)];
            else sq = m_ackd;
          end
          default: sq = $urandom_range(0, MODN - 1);
        endcase
      end
      if (m_phase == 1 && $urandom_range(0, 3) == 0) a = 1;
      if (m_phase == 2 && $urandom_range(0, 3) == 0) d = 1;
      cycle(s, dv, nk, sq, a, d);
      got = {next_seq_o, purge_seq_o, purge_valid_o, dllp_err_o, replay_req_o, retrain_req_o, tx_stall_o};
      exp = {12'(m_next), 12'(m_ackd), e_purge, e_err, m_phase == 1, e_retrain, m_q.size() >= 2047};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL random_outputs cycle=%0d got=%h exp=%h", c, got, exp);
      end
      checks++;
      if (dut.replay_num !== 2'(m_rnum)) begin
        failures++; $display("FAIL random_rnum cycle=%0d got=%0d exp=%0d", c, dut.replay_num, m_rnum);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_ack();
    test_nak();
    test_timer_retrain();
    test_wrap();
    test_stall();
    test_ack_wins();
    test_expiry_nak_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
